// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a five-stage pipeline: load-use stalls, MEM-stage redirects,
// memory wait states and EX forwarding selects. Optional perf counters under PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic             ex_wr_en,
   input  logic [4:0]       ex_write_reg,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             mem_wr_en,
   input  logic             wb_wr_en,
   input  logic [4:0]       mem_write_reg,
   input  logic [4:0]       wb_write_reg,
   input  logic             mem_redirect,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;
   localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);

   logic [1:0] state_q, state_d, ret_q, ret_d, eff_state;
   logic [2:0] rem_q, rem_d;
   logic [4:0] en_vec;
   logic [2:0] fl_vec;
   logic       load_use;

   // ex_wr_en is implied by ex_mem_read for a load, so only the load flag gates the hazard.
   assign load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
                     ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

   // While held, the interrupted state is evaluated as soon as mem_ready returns.
   assign eff_state = (state_q == S_HOLD) ? ret_q : state_q;

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      rem_d   = rem_q;
      en_vec  = 5'b00000;
      fl_vec  = 3'b000;
      case (eff_state)
         S_INIT: begin
            fl_vec  = 3'b111;
            state_d = S_RUN;
         end
         S_RUN, S_STALL: begin
            if (!mem_ready) begin
               state_d = S_HOLD;
               ret_d   = eff_state;
            end else if (mem_redirect) begin
               en_vec  = 5'b11111;
               fl_vec  = 3'b111;
               state_d = S_RUN;
               rem_d   = 3'd0;
            end else if ((eff_state == S_STALL) || load_use) begin
               en_vec = 5'b00111;
               fl_vec = 3'b010;
               if (eff_state == S_RUN) begin
                  state_d = (REM_INIT != 3'd0) ? S_STALL : S_RUN;
                  rem_d   = REM_INIT;
               end else if (rem_q <= 3'd1) begin
                  state_d = S_RUN;
                  rem_d   = 3'd0;
               end else begin
                  state_d = S_STALL;
                  rem_d   = rem_q - 3'd1;
               end
            end else begin
               en_vec  = 5'b11111;
               state_d = S_RUN;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         ret_q   <= S_RUN;
         rem_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         rem_q   <= rem_d;
      end
   end

   assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en_vec;
   assign {if_id_flush, id_ex_flush, ex_mem_flush}          = fl_vec;
   assign dbg_state = state_q;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (mem_wr_en && (mem_write_reg != 5'd0) && (mem_write_reg == src)) return 2'b01;
      else if (wb_wr_en && (wb_write_reg != 5'd0) && (wb_write_reg == src)) return 2'b10;
      else return 2'b00;
   endfunction

   assign fwd_a = fwd_sel(ex_rs);
   assign fwd_b = fwd_sel(ex_rt);

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             stall_inc, flush_inc;

   // A bubble flushes ID/EX alone; a redirect flushes EX/MEM with enables on (INIT has them off).
   assign stall_inc = id_ex_flush && !if_id_flush;
   assign flush_inc = ex_mem_flush && ex_mem_en;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_ex_wr;
   assign unused_ex_wr = ex_wr_en;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

`ifdef PIPE_PERF_CNT_EN
   logic unused_ex_wr_cnt;
   assign unused_ex_wr_cnt = ex_wr_en;
`endif

endmodule
